// File: rtl/eth_frame_log_arbiter_pkg.sv
// Shared types and constants for the frame log arbiter: FSM states, control
// record layout, header field positions and the data-word count helper.
package eth_frame_log_pkg;

  localparam int LOG_DATA_W = 64;
  localparam int CTL_W      = 120;
  localparam int FRAME_W    = 64;

  localparam int HDR_SRC_LSB     = 56;
  localparam int HDR_MATCHED_LSB = 48;
  localparam int HDR_SIZE_LSB    = 32;
  localparam int HDR_NUMBER_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA
  } state_e;

  // Field order matches the packed control word, MATCHED in the top byte.
  typedef struct packed {
    logic [7:0]  matched;
    logic [15:0] size;
    logic [31:0] number;
    logic [63:0] timestamp;
  } ctl_rec_t;

  // 17-bit arithmetic so SIZE=0xFFFF rounds up to 8192 words without overflow.
  function automatic logic [16:0] word_count(input logic [15:0] size);
    return ({1'b0, size} + 17'd7) >> 3;
  endfunction

  function automatic logic [LOG_DATA_W-1:0] make_header(input logic [7:0] src,
                                                        input ctl_rec_t rec);
    logic [LOG_DATA_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_SRC_LSB +: 8]      = src;
    hdr[HDR_MATCHED_LSB +: 8]  = rec.matched;
    hdr[HDR_SIZE_LSB +: 16]    = rec.size;
    hdr[HDR_NUMBER_LSB +: 32]  = rec.number;
    return hdr;
  endfunction

endpackage

// File: rtl/eth_frame_log_arbiter_if.sv
// Merged log output stream (AXI-Stream style): data, valid, last, ready.
interface eth_frame_log_arbiter_if;
  import eth_frame_log_pkg::*;

  logic [LOG_DATA_W-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/eth_frame_log_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after start_i,
// wrapping, returned both one-hot and as an index.
module eth_log_rr_select #(
  parameter int C_NUM_SOURCES = 4,
  parameter int C_IDX_W       = 2
) (
  input  logic [C_NUM_SOURCES-1:0] req_i,
  input  logic [C_IDX_W-1:0]       start_i,
  output logic [C_NUM_SOURCES-1:0] gnt_o,
  output logic [C_IDX_W-1:0]       idx_o,
  output logic                     any_o
);

  localparam int SUM_W = C_IDX_W + 1;

  always_comb begin : p_pick
    logic [SUM_W-1:0]   sum;
    logic [C_IDX_W-1:0] pos;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < C_NUM_SOURCES; k++) begin
      sum = {1'b0, start_i} + SUM_W'(k);
      if (sum >= SUM_W'(C_NUM_SOURCES)) begin
        sum = sum - SUM_W'(C_NUM_SOURCES);
      end
      pos = sum[C_IDX_W-1:0];
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/eth_frame_log_arbiter.sv
// Merges per-source control records and frame words into one log stream.
// Build macro ETH_FRAME_LOG_ARB_DROP_EN: silently drain MATCHED==0 records.
//
// state    | meaning
// ST_IDLE  | wait for enable and a control request; grant and latch record
// ST_HDR0  | emit timestamp word
// ST_HDR1  | emit {source, matched, size, number}; last if size is zero
// ST_DATA  | pass granted frame words through (or drain them when dropping)
module eth_frame_log_arbiter
  import eth_frame_log_pkg::*;
#(
  parameter int C_NUM_SOURCES     = 4,
  parameter int C_MAX_FRAME_WORDS = 8192
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [CTL_W*C_NUM_SOURCES-1:0]     s_axis_ctl_tdata,
  input  logic [C_NUM_SOURCES-1:0]           s_axis_ctl_tvalid,
  output logic [C_NUM_SOURCES-1:0]           s_axis_ctl_tready,
  input  logic [FRAME_W*C_NUM_SOURCES-1:0]   s_axis_frame_tdata,
  input  logic [C_NUM_SOURCES-1:0]           s_axis_frame_tvalid,
  output logic [C_NUM_SOURCES-1:0]           s_axis_frame_tready,
  eth_frame_log_arbiter_if.master            m_axis,
  output logic [31:0]                        records_sent
);

  localparam int IDX_W = (C_NUM_SOURCES > 1) ? $clog2(C_NUM_SOURCES) : 1;
  localparam int CNT_W = $clog2(C_MAX_FRAME_WORDS + 1);

`ifdef ETH_FRAME_LOG_ARB_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  ctl_rec_t              ctl_rec    [C_NUM_SOURCES];
  logic [FRAME_W-1:0]    frame_word [C_NUM_SOURCES];

  for (genvar g = 0; g < C_NUM_SOURCES; g++) begin : g_unpack
    assign ctl_rec[g]    = ctl_rec_t'(s_axis_ctl_tdata[g*CTL_W +: CTL_W]);
    assign frame_word[g] = s_axis_frame_tdata[g*FRAME_W +: FRAME_W];
  end

  state_e             state_q, state_d;
  ctl_rec_t           rec_q, rec_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic [31:0]        records_q, records_d;

  logic [C_NUM_SOURCES-1:0] rr_gnt;
  logic [IDX_W-1:0]         rr_idx;
  logic                     rr_any;
  ctl_rec_t                 sel_rec;

  logic [C_NUM_SOURCES-1:0] ctl_tready_c, frame_tready_c;
  logic [LOG_DATA_W-1:0]    tdata_c;
  logic                     tvalid_c, tlast_c;

  eth_log_rr_select #(
    .C_NUM_SOURCES (C_NUM_SOURCES),
    .C_IDX_W       (IDX_W)
  ) u_rr_select (
    .req_i   (s_axis_ctl_tvalid),
    .start_i (ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  assign sel_rec = ctl_rec[rr_idx];

  always_comb begin
    state_d        = state_q;
    rec_d          = rec_q;
    src_d          = src_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    drop_d         = drop_q;
    records_d      = records_q;
    ctl_tready_c   = '0;
    frame_tready_c = '0;
    tdata_c        = '0;
    tvalid_c       = 1'b0;
    tlast_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && rr_any) begin
          ctl_tready_c = rr_gnt;
          rec_d        = sel_rec;
          src_d        = rr_idx;
          ptr_d        = (rr_idx == IDX_W'(C_NUM_SOURCES - 1)) ? '0 : rr_idx + IDX_W'(1);
          cnt_d        = CNT_W'(word_count(sel_rec.size));
          drop_d       = DROP_EN && (sel_rec.matched == 8'd0);
          if (drop_d) begin
            // A dropped record skips the headers and only drains its frame words.
            state_d = (sel_rec.size != 16'd0) ? ST_DATA : ST_IDLE;
          end else begin
            state_d = ST_HDR0;
          end
        end
      end
      ST_HDR0: begin
        tdata_c  = rec_q.timestamp;
        tvalid_c = 1'b1;
        if (m_axis.tready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        tdata_c  = make_header(8'(src_q), rec_q);
        tvalid_c = 1'b1;
        tlast_c  = (rec_q.size == 16'd0);
        if (m_axis.tready) begin
          if (tlast_c) begin
            state_d   = ST_IDLE;
            records_d = records_q + 32'd1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (drop_q) begin
          frame_tready_c[src_q] = 1'b1;
          if (s_axis_frame_tvalid[src_q]) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          end
        end else begin
          tdata_c               = frame_word[src_q];
          tvalid_c              = s_axis_frame_tvalid[src_q];
          tlast_c               = (cnt_q == CNT_W'(1));
          frame_tready_c[src_q] = m_axis.tready;
          if (tvalid_c && m_axis.tready) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (tlast_c) begin
              state_d   = ST_IDLE;
              records_d = records_q + 32'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs go quiet the same cycle reset is asserted, not one edge later.
    if (!rst_n) begin
      ctl_tready_c   = '0;
      frame_tready_c = '0;
      tdata_c        = '0;
      tvalid_c       = 1'b0;
      tlast_c        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      src_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      records_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      records_q <= records_d;
    end
  end

  assign s_axis_ctl_tready   = ctl_tready_c;
  assign s_axis_frame_tready = frame_tready_c;
  assign m_axis.tdata        = tdata_c;
  assign m_axis.tvalid       = tvalid_c;
  assign m_axis.tlast        = tlast_c;
  assign records_sent        = records_q;

endmodule

// File: doc/eth_frame_log_arbiter.md
ETH_FRAME_LOG_ARBITER -- requirements
Module: eth_frame_log_arbiter

Interface
REQ-001 Parameter C_NUM_SOURCES, default 4, number of extractor channels merged (1..8).
REQ-002 Parameter C_MAX_FRAME_WORDS, default 8192, upper bound on data words per record; sets the word counter width.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  grant new records when high.
REQ-006 s_axis_ctl_tdata  input  120*C_NUM_SOURCES  per-source {MATCHED[119:112], SIZE[111:96], NUMBER[95:64], TIMESTAMP[63:0]}.
REQ-007 s_axis_ctl_tvalid / s_axis_ctl_tready  input / output  C_NUM_SOURCES  per-source control handshake.
REQ-008 s_axis_frame_tdata  input  64*C_NUM_SOURCES  per-source frame bytes, byte 0 in bits [7:0].
REQ-009 s_axis_frame_tvalid / s_axis_frame_tready  input / output  C_NUM_SOURCES  per-source frame handshake.
REQ-010 m_axis_tdata  output  64  merged log stream.
REQ-011 m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-012 records_sent  output  32  count of records whose tlast beat was accepted.

Function
REQ-013 States: ST_IDLE, ST_HDR0, ST_HDR1, ST_DATA.
REQ-014 ST_IDLE: if enable and any ctl_tvalid, grant round-robin, starting at index after last grant (index 0 after reset); latch grant's ctl_tdata; pulse that ctl_tready for exactly that cycle; go ST_HDR0.
REQ-015 ST_HDR0: m_axis_tdata = TIMESTAMP, tvalid=1, tlast=0; on tready go ST_HDR1.
REQ-016 ST_HDR1: m_axis_tdata = {8'(source index), MATCHED, SIZE, NUMBER}; tlast=1 iff SIZE==0; on tready go ST_DATA if SIZE!=0, else ST_IDLE.
REQ-017 Data word count = ceil(SIZE/8), computed as (SIZE+7)>>3 in 17 bits; SIZE=0xFFFF yields 8192.
REQ-018 ST_DATA: m_axis_tdata/tvalid combinationally follow granted frame source; granted frame_tready = m_axis_tready; all other readies 0; tlast on last counted word; after that beat accepted go ST_IDLE.
REQ-019 Header states hold tdata/tvalid stable until accepted; no tvalid retraction.
REQ-020 Exactly one idle cycle between consecutive records; ctl_tready never asserted outside ST_IDLE.
REQ-021 enable deassert mid-record: current record completes; no new grant until enable high.
REQ-022 records_sent increments by 1 per accepted tlast beat; wraps 0xFFFFFFFF->0.
REQ-023 Source ctl valid while another source in ST_DATA: waits; no starvation (max wait C_NUM_SOURCES-1 records).

Reset
REQ-024 rst_n low: state ST_IDLE, m_axis_tvalid=0, m_axis_tlast=0, all s_axis readies 0, m_axis_tdata=0, grant pointer 0, word counter 0, records_sent=0.
REQ-025 Reset mid-record aborts it with no tlast emitted; unconsumed frame words remain in source FIFOs.

Configuration
REQ-026 Macro ETH_FRAME_LOG_ARB_DROP_EN defined: records with MATCHED==0 (extractor overflow entries) emit no output; ST_DATA-equivalent draining consumes ceil(SIZE/8) frame words with frame_tready=1, m_axis_tvalid=0; records_sent unchanged.
REQ-027 Macro undefined: MATCHED==0 records forwarded like any other.

Structure
REQ-028 Package eth_frame_log_pkg: state enum, ctl record struct (matched, size, number, timestamp), header field offsets, log data width constant 64.
REQ-029 Sub-module eth_log_rr_select: combinational round-robin picker (request vector, last grant -> one-hot grant, index).

Verification
REQ-030 Src0 ctl SIZE=20, 3 frame words, tready=1 -> beats TIMESTAMP, header {0,MATCHED,20,NUMBER}, 3 data, tlast on beat 5; records_sent=1.
REQ-031 Src1 ctl SIZE=0 -> 2 beats, tlast on header1, frame_tready[1] never high.
REQ-032 All 4 sources valid continuously, SIZE=8 -> grant order 0,1,2,3,0; one idle cycle between records.
REQ-033 m_axis_tready toggled 1/0 per cycle during SIZE=64 record -> 10 beats, data unchanged while stalled, no drops/duplicates.
REQ-034 DROP_EN defined, ctl MATCHED=0 SIZE=16 -> 2 frame words consumed, no m_axis_tvalid, records_sent unchanged; undefined -> 4 beats output.
REQ-035 rst_n low during ST_DATA word 2 of 4 -> next cycle all tvalid/tready 0, records_sent=0, grant restarts at source 0.
